// File: rtl/accel_pkg.sv
// Shared definitions for the accelerometer averaging path: FSM encodings,
// per-axis control strobes and width helpers.
package accel_pkg;

    localparam int P_DATA_W_DEF = 16;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_EMIT  = 2'd2;

    typedef struct packed {
        logic load;
        logic update;
        logic emit;
        logic clear;
    } axis_ctrl_t;

    // Bits needed to hold values 0..value-1.
    function automatic int clogb2(input int value);
        int res;
        res = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            res++;
        end
        return res;
    endfunction

    // The running sum of 2^avg_log2 samples needs avg_log2 extra bits.
    function automatic int acc_w(input int data_w, input int avg_log2);
        return data_w + avg_log2;
    endfunction

endpackage

// File: rtl/accel_avg_filter_if.sv
// Sample input / averaged output bundle between the ADXL362 controller side
// and the averaging filter. The filter takes the slave modport.
interface accel_avg_filter_if
    import accel_pkg::*;
#(
    parameter int P_DATA_W = P_DATA_W_DEF,
    parameter int P_OVR_W  = 8
) ();
    // sample_rdy_i is a level or pulse: a sample is offered on each rising edge,
    // there is no back-pressure; edges arriving while the filter is busy are
    // dropped and counted in overrun_o. valid_o is a one-cycle strobe.
    logic [P_DATA_W-1:0] ax_i;
    logic [P_DATA_W-1:0] ay_i;
    logic [P_DATA_W-1:0] az_i;
    logic                sample_rdy_i;
    logic                clear_i;
    logic [P_DATA_W-1:0] avg_x_o;
    logic [P_DATA_W-1:0] avg_y_o;
    logic [P_DATA_W-1:0] avg_z_o;
    logic                valid_o;
    logic                primed_o;
    logic [P_OVR_W-1:0]  overrun_o;
    logic [1:0]          dbg_state_o;

    modport slave (
        input  ax_i, ay_i, az_i, sample_rdy_i, clear_i,
        output avg_x_o, avg_y_o, avg_z_o, valid_o, primed_o, overrun_o, dbg_state_o
    );

    modport master (
        output ax_i, ay_i, az_i, sample_rdy_i, clear_i,
        input  avg_x_o, avg_y_o, avg_z_o, valid_o, primed_o, overrun_o, dbg_state_o
    );

endinterface

// File: rtl/accel_axis_avg.sv
// One axis of the boxcar filter: circular sample buffer, running sum, write
// pointer and average register, sequenced by strobes from the top-level FSM.
module accel_axis_avg
    import accel_pkg::*;
#(
    parameter int P_DATA_W   = P_DATA_W_DEF,
    parameter int P_AVG_LOG2 = 3
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  axis_ctrl_t          ctrl_i,
    input  logic [P_DATA_W-1:0] sample_i,
    output logic [P_DATA_W-1:0] avg_o
);
    localparam int N     = 1 << P_AVG_LOG2;
    localparam int ACC_W = acc_w(P_DATA_W, P_AVG_LOG2);

    logic [P_DATA_W-1:0]     mem_q [N];
    logic [P_DATA_W-1:0]     mem_d [N];
    logic [P_DATA_W-1:0]     sample_q, sample_d;
    logic [P_DATA_W-1:0]     oldest_q, oldest_d;
    logic signed [ACC_W-1:0] sum_q, sum_d;
    logic [P_AVG_LOG2-1:0]   ptr_q, ptr_d;
    logic [P_DATA_W-1:0]     avg_q, avg_d;
    logic signed [ACC_W-1:0] samp_ext;
    logic signed [ACC_W-1:0] old_ext;

    assign samp_ext = ACC_W'($signed(sample_q));
    assign old_ext  = ACC_W'($signed(oldest_q));

    always_comb begin
        mem_d    = mem_q;
        sample_d = sample_q;
        oldest_d = oldest_q;
        sum_d    = sum_q;
        ptr_d    = ptr_q;
        avg_d    = avg_q;
        if (ctrl_i.clear) begin
            for (int i = 0; i < N; i++) begin
                mem_d[i] = '0;
            end
            sample_d = '0;
            oldest_d = '0;
            sum_d    = '0;
            ptr_d    = '0;
            avg_d    = '0;
        end else begin
            if (ctrl_i.load) begin
                sample_d = sample_i;
                oldest_d = mem_q[ptr_q];
            end
            // The evicted entry is zero until the window first fills, which
            // gives the zero-padded partial average before priming.
            if (ctrl_i.update) begin
                sum_d        = sum_q + samp_ext - old_ext;
                mem_d[ptr_q] = sample_q;
                ptr_d        = ptr_q + 1'b1;
            end
            if (ctrl_i.emit) begin
                avg_d = P_DATA_W'(sum_q >>> P_AVG_LOG2);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < N; i++) begin
                mem_q[i] <= '0;
            end
            sample_q <= '0;
            oldest_q <= '0;
            sum_q    <= '0;
            ptr_q    <= '0;
            avg_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            sample_q <= sample_d;
            oldest_q <= oldest_d;
            sum_q    <= sum_d;
            ptr_q    <= ptr_d;
            avg_q    <= avg_d;
        end
    end

    assign avg_o = avg_q;

endmodule

// File: rtl/accel_avg_filter.sv
// Per-axis boxcar moving average over 2^P_AVG_LOG2 ADXL362 samples, with
// rising-edge sample capture, fill tracking and a saturating overrun count.
module accel_avg_filter
    import accel_pkg::*;
#(
    parameter int P_DATA_W   = P_DATA_W_DEF,
    parameter int P_AVG_LOG2 = 3,
    parameter int P_OVR_W    = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    accel_avg_filter_if.slave bus
);
    localparam int N      = 1 << P_AVG_LOG2;
    localparam int FILL_W = clogb2(N + 1);

    logic [1:0]         state_q, state_d;
    logic               rdy_q, rdy_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               primed_q, primed_d;
    logic               valid_q, valid_d;
    logic [P_OVR_W-1:0] overrun_q, overrun_d;
    axis_ctrl_t         ctrl;
    logic               rise;
    logic               full;

    assign rise = bus.sample_rdy_i & ~rdy_q;
    assign full = (fill_q == FILL_W'(N));

    always_comb begin
        state_d   = state_q;
        rdy_d     = bus.sample_rdy_i;
        fill_d    = fill_q;
        primed_d  = primed_q;
        valid_d   = 1'b0;
        overrun_d = overrun_q;
        ctrl      = '0;
        // A rise coinciding with clear is discarded without counting.
        if (bus.clear_i) begin
            ctrl.clear = 1'b1;
            state_d    = S_IDLE;
            fill_d     = '0;
            primed_d   = 1'b0;
        end else begin
            if (rise && state_q != S_IDLE && overrun_q != {P_OVR_W{1'b1}}) begin
                overrun_d = overrun_q + 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (rise) begin
                        ctrl.load = 1'b1;
                        state_d   = S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    ctrl.update = 1'b1;
                    if (!full) begin
                        fill_d = fill_q + 1'b1;
                    end
                    state_d = S_EMIT;
                end
                S_EMIT: begin
                    ctrl.emit = 1'b1;
                    primed_d  = full;
                    valid_d   = full;
                    state_d   = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            rdy_q     <= 1'b1;
            fill_q    <= '0;
            primed_q  <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= '0;
        end else begin
            state_q   <= state_d;
            rdy_q     <= rdy_d;
            fill_q    <= fill_d;
            primed_q  <= primed_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    accel_axis_avg #(.P_DATA_W(P_DATA_W), .P_AVG_LOG2(P_AVG_LOG2)) u_axis_x (
        .clk_i(clk_i), .rst_ni(rst_ni), .ctrl_i(ctrl), .sample_i(bus.ax_i), .avg_o(bus.avg_x_o)
    );
    accel_axis_avg #(.P_DATA_W(P_DATA_W), .P_AVG_LOG2(P_AVG_LOG2)) u_axis_y (
        .clk_i(clk_i), .rst_ni(rst_ni), .ctrl_i(ctrl), .sample_i(bus.ay_i), .avg_o(bus.avg_y_o)
    );
    accel_axis_avg #(.P_DATA_W(P_DATA_W), .P_AVG_LOG2(P_AVG_LOG2)) u_axis_z (
        .clk_i(clk_i), .rst_ni(rst_ni), .ctrl_i(ctrl), .sample_i(bus.az_i), .avg_o(bus.avg_z_o)
    );

    assign bus.valid_o     = valid_q;
    assign bus.primed_o    = primed_q;
    assign bus.overrun_o   = overrun_q;
    assign bus.dbg_state_o = state_q;

endmodule

// File: tb/tb_accel_avg_filter.sv
// Directed bench for accel_avg_filter: a table of hand-computed sample/average
// records plus sequences for level-ready, overrun, clear and mid-update reset.
module tb_accel_avg_filter;
    import accel_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    accel_avg_filter_if #(.P_DATA_W(16), .P_OVR_W(8)) bus ();

    accel_avg_filter #(.P_DATA_W(16), .P_AVG_LOG2(3), .P_OVR_W(8)) dut (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] x, y, z;
        logic [15:0] ex, ey, ez;
        logic        ev, ep;
    } vec_t;

    vec_t tbl[32];

    function automatic vec_t mk(input logic [15:0] x, y, ex, ey, input logic ev, ep);
        vec_t v;
        v.x = x; v.y = y; v.z = 16'h0000;
        v.ex = ex; v.ey = ey; v.ez = 16'h0000;
        v.ev = ev; v.ep = ep;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Rise at edge T, outputs observed just after edge T+2.
    task automatic send(input logic [15:0] x, y, z);
        bus.ax_i = x; bus.ay_i = y; bus.az_i = z;
        bus.sample_rdy_i = 1'b1;
        step();
        bus.sample_rdy_i = 1'b0;
        step();
        step();
    endtask

    int vcount;

    initial begin
        bus.ax_i = '0; bus.ay_i = '0; bus.az_i = '0;
        bus.sample_rdy_i = 1'b0; bus.clear_i = 1'b0;

        for (int k = 1; k <= 7; k++) begin
            logic [15:0] eyk [7];
            eyk = '{16'hFFFF, 16'hFFFF, 16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFFFD, 16'hFFFD};
            tbl[k-1] = mk(16'd16, 16'hFFFD, 16'(2 * k), eyk[k-1], 1'b0, 1'b0);
        end
        tbl[7]  = mk(16'd16,  16'hFFFD, 16'd16,  16'hFFFD, 1'b1, 1'b1);
        tbl[8]  = mk(16'd100, 16'hFFFD, 16'd26,  16'hFFFD, 1'b1, 1'b1);
        tbl[9]  = mk(16'd100, 16'hFFFD, 16'd37,  16'hFFFD, 1'b1, 1'b1);
        tbl[10] = mk(16'd100, 16'hFFFD, 16'd47,  16'hFFFD, 1'b1, 1'b1);
        tbl[11] = mk(16'd100, 16'hFFFD, 16'd58,  16'hFFFD, 1'b1, 1'b1);
        tbl[12] = mk(16'd100, 16'hFFFD, 16'd68,  16'hFFFD, 1'b1, 1'b1);
        tbl[13] = mk(16'd100, 16'hFFFD, 16'd79,  16'hFFFD, 1'b1, 1'b1);
        tbl[14] = mk(16'd100, 16'hFFFD, 16'd89,  16'hFFFD, 1'b1, 1'b1);
        tbl[15] = mk(16'd100, 16'hFFFD, 16'd100, 16'hFFFD, 1'b1, 1'b1);
        tbl[16] = mk(16'd0,   16'hFFFD, 16'd87,  16'hFFFD, 1'b1, 1'b1);
        tbl[17] = mk(16'd0,   16'hFFFD, 16'd75,  16'hFFFD, 1'b1, 1'b1);
        tbl[18] = mk(16'd0,   16'hFFFD, 16'd62,  16'hFFFD, 1'b1, 1'b1);
        tbl[19] = mk(16'd0,   16'hFFFD, 16'd50,  16'hFFFD, 1'b1, 1'b1);
        tbl[20] = mk(16'd0,   16'hFFFD, 16'd37,  16'hFFFD, 1'b1, 1'b1);
        tbl[21] = mk(16'd0,   16'hFFFD, 16'd25,  16'hFFFD, 1'b1, 1'b1);
        tbl[22] = mk(16'd0,   16'hFFFD, 16'd12,  16'hFFFD, 1'b1, 1'b1);
        tbl[23] = mk(16'd0,   16'hFFFD, 16'd0,   16'hFFFD, 1'b1, 1'b1);
        for (int k = 0; k < 8; k++) begin
            tbl[24+k] = mk((k % 2 == 0) ? 16'hFFFF : 16'h0000, 16'hFFFD, 16'hFFFF, 16'hFFFD, 1'b1, 1'b1);
        end

        // Reset state
        repeat (3) step();
        chk("rst_avg_x", 32'(bus.avg_x_o), 32'd0);
        chk("rst_avg_y", 32'(bus.avg_y_o), 32'd0);
        chk("rst_valid", 32'(bus.valid_o), 32'd0);
        chk("rst_primed", 32'(bus.primed_o), 32'd0);
        chk("rst_overrun", 32'(bus.overrun_o), 32'd0);
        chk("rst_state", 32'(bus.dbg_state_o), 32'(S_IDLE));
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 32; i++) begin
            send(tbl[i].x, tbl[i].y, tbl[i].z);
            chk($sformatf("vec%0d_valid", i), 32'(bus.valid_o), 32'(tbl[i].ev));
            chk($sformatf("vec%0d_primed", i), 32'(bus.primed_o), 32'(tbl[i].ep));
            chk($sformatf("vec%0d_avg_x", i), 32'(bus.avg_x_o), 32'(tbl[i].ex));
            chk($sformatf("vec%0d_avg_y", i), 32'(bus.avg_y_o), 32'(tbl[i].ey));
            chk($sformatf("vec%0d_avg_z", i), 32'(bus.avg_z_o), 32'(tbl[i].ez));
        end
        step();
        chk("valid_one_cycle", 32'(bus.valid_o), 32'd0);

        // Level held high: one sample of x=64 evicts the oldest -1 -> sum 61 -> 7
        bus.ax_i = 16'd64; bus.ay_i = 16'hFFFD; bus.az_i = 16'd0;
        bus.sample_rdy_i = 1'b1;
        vcount = 0;
        for (int c = 0; c < 50; c++) begin
            step();
            if (bus.valid_o) vcount++;
        end
        bus.sample_rdy_i = 1'b0;
        step();
        chk("level_one_sample", 32'(vcount), 32'd1);
        chk("level_avg_x", 32'(bus.avg_x_o), 32'd7);
        chk("level_no_overrun", 32'(bus.overrun_o), 32'd0);

        // Second rise two cycles after the first lands in S_EMIT and is dropped
        for (int n = 0; n < 301; n++) begin
            bus.sample_rdy_i = 1'b1; step();
            bus.sample_rdy_i = 1'b0; step();
            bus.sample_rdy_i = 1'b1; step();
            bus.sample_rdy_i = 1'b0; step();
            if (n == 0) chk("overrun_one", 32'(bus.overrun_o), 32'd1);
        end
        chk("overrun_sat", 32'(bus.overrun_o), 32'd255);
        chk("pre_clear_primed", 32'(bus.primed_o), 32'd1);

        // Clear together with a rise while primed
        bus.clear_i = 1'b1; bus.sample_rdy_i = 1'b1;
        step();
        bus.clear_i = 1'b0;
        chk("clr_avg_x", 32'(bus.avg_x_o), 32'd0);
        chk("clr_avg_y", 32'(bus.avg_y_o), 32'd0);
        chk("clr_avg_z", 32'(bus.avg_z_o), 32'd0);
        chk("clr_primed", 32'(bus.primed_o), 32'd0);
        chk("clr_valid", 32'(bus.valid_o), 32'd0);
        chk("clr_overrun", 32'(bus.overrun_o), 32'd255);
        vcount = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (bus.valid_o) vcount++;
        end
        chk("clr_rise_discarded", 32'(bus.dbg_state_o), 32'(S_IDLE));
        chk("clr_no_valid", 32'(vcount), 32'd0);
        bus.sample_rdy_i = 1'b0;
        step();
        for (int k = 1; k <= 8; k++) begin
            send(16'd8, 16'd0, 16'hFFF8);
            chk($sformatf("refill%0d_valid", k), 32'(bus.valid_o), (k == 8) ? 32'd1 : 32'd0);
        end
        chk("refill_avg_x", 32'(bus.avg_x_o), 32'd8);
        chk("refill_avg_z", 32'(bus.avg_z_o), 32'hFFF8);
        chk("refill_overrun_kept", 32'(bus.overrun_o), 32'd255);

        // Reset in S_ACCUM with sample_rdy_i held high through and after reset
        bus.sample_rdy_i = 1'b1;
        step();
        chk("pre_rst_state", 32'(bus.dbg_state_o), 32'(S_ACCUM));
        rst_n = 1'b0;
        step();
        chk("mid_rst_avg_x", 32'(bus.avg_x_o), 32'd0);
        chk("mid_rst_avg_z", 32'(bus.avg_z_o), 32'd0);
        chk("mid_rst_valid", 32'(bus.valid_o), 32'd0);
        chk("mid_rst_primed", 32'(bus.primed_o), 32'd0);
        chk("mid_rst_overrun", 32'(bus.overrun_o), 32'd0);
        chk("mid_rst_state", 32'(bus.dbg_state_o), 32'(S_IDLE));
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) step();
        chk("level_through_rst", 32'(bus.dbg_state_o), 32'(S_IDLE));
        bus.sample_rdy_i = 1'b0; step();
        bus.sample_rdy_i = 1'b1; step();
        chk("rise_after_rst", 32'(bus.dbg_state_o), 32'(S_ACCUM));
        bus.sample_rdy_i = 1'b0;
        step(); step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
